// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: combinational read of one index; REG_FILE_BYPASS_EN adds write-first bypass
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REG_FILE_BYPASS_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
`endif
    output logic [DATA_W-1:0] data
);
    logic is_zero;
    assign is_zero = idx == ADDR_W'(ZERO_REG);
`ifdef REG_FILE_BYPASS_EN
    always_comb data = (rst || is_zero) ? '0 : (we && waddr == idx) ? wdata : regs[idx];
`else
    always_comb data = (rst || is_zero) ? '0 : regs[idx];
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two async read ports; REG_FILE_BYPASS_EN enables write-first bypass
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic              we;
    assign we = reg_write && write_reg != ADDR_W'(ZERO_REG);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (we) begin
            regs[write_reg] <= write_data;
        end
    end
    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .rst  (rst),
        .idx  (read_reg1),
        .regs (regs),
`ifdef REG_FILE_BYPASS_EN
        .we   (we),
        .waddr(write_reg),
        .wdata(write_data),
`endif
        .data (read_data1)
    );
    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .rst  (rst),
        .idx  (read_reg2),
        .regs (regs),
`ifdef REG_FILE_BYPASS_EN
        .we   (we),
        .waddr(write_reg),
        .wdata(write_data),
`endif
        .data (read_data2)
    );
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, the register and data width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 5, the register index width, giving 2**ADDR_W registers.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port reg_write SHALL be an input, 1 bit: write enable for the write port.
REQ-006 Port write_reg SHALL be an input, ADDR_W bits: write port register index.
REQ-007 Port write_data SHALL be an input, DATA_W bits: write port data.
REQ-008 Port read_reg1 SHALL be an input, ADDR_W bits: read port 1 register index.
REQ-009 Port read_reg2 SHALL be an input, ADDR_W bits: read port 2 register index.
REQ-010 Port read_data1 SHALL be an output, DATA_W bits: operand feeding ALU data1.
REQ-011 Port read_data2 SHALL be an output, DATA_W bits: operand feeding ALU data2.

Function
REQ-012 Read ports SHALL be combinational, so read_dataN reflects the stored value of read_regN within the same cycle with zero clock latency.
REQ-013 When reg_write=1 and write_reg!=0 at a rising clk edge, register[write_reg] SHALL take write_data on that edge.
REQ-014 When reg_write=0, no register SHALL change.
REQ-015 Register 0 SHALL read as all-zeros at all times, and writes to index 0 SHALL be discarded.
REQ-016 Both ports SHALL support reading the same index simultaneously, each returning the identical value.
REQ-017 A read of an index being written in the same cycle SHALL return the old value unless REG_FILE_BYPASS_EN is defined (REQ-021).
REQ-018 Indices SHALL be unsigned, with no out-of-range condition: all 2**ADDR_W values are valid.

Reset
REQ-019 While rst=1 at a rising clk edge, every register SHALL clear to 0, and rst SHALL take priority over a coincident write.
REQ-020 During and after reset, read_data1 and read_data2 SHALL equal 0 for every index until a subsequent write.

Configuration
REQ-021 With REG_FILE_BYPASS_EN defined, when reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN SHALL equal write_data combinationally (write-first); rst=1 SHALL suppress the bypass so that reads return 0.
REQ-022 Without REG_FILE_BYPASS_EN, the bypass logic SHALL be absent and REQ-017 read-old behaviour SHALL hold.

Structure
REQ-023 The shared package SHALL hold DATA_W/ADDR_W default constants and the ZERO_REG index constant (0).
REQ-024 The read path SHALL be a sub-module reg_file_read_port (index in, storage array and bypass inputs in, data out), instantiated twice.
REQ-025 Storage SHALL be a single array of 2**ADDR_W x DATA_W flops, with no other sequential state.

Verification
REQ-026 Reset: apply rst=1 for one edge after random writes, then read all 32 indices -> every read_data = 0x00000000.
REQ-027 Basic write/read: write 0xDEADBEEF to r5, then set read_reg1=5 and read_reg2=5 -> both outputs = 0xDEADBEEF.
REQ-028 Zero register: write 0x12345678 to r0, then read r0 -> 0x00000000.
REQ-029 Same-cycle read/write: r7 holds 0x1 and the bench writes 0x2 to r7 while reading r7 -> 0x1 without the macro, 0x2 with REG_FILE_BYPASS_EN; the read after the edge -> 0x2 in both builds.
REQ-030 Reset versus write: rst=1 and reg_write=1 (r3 = 0xFFFFFFFF) on the same edge -> r3 reads 0x00000000.
REQ-031 ALU hookup: write r1=1 and r2=2, drive read_reg1=1 and read_reg2=2 into the ALU with aluoperation=0111 -> result=1 and lt=1.
